// File: rtl/traffic_sensor_conditioner.sv
// Loop-detector synchronizer/window counter and pedestrian request holder for the intersection controller.
// Optional button debouncer is enabled by defining PED_DEBOUNCE_EN.
module traffic_sensor_conditioner #(
  parameter int WINDOW_CYCLES   = 64,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mainSensorRaw,
  input  logic       sideSensorRaw,
  input  logic       pedButtonRaw,
  input  logic       pedServed,
  output logic [2:0] mainTraffic,
  output logic [2:0] sideTraffic,
  output logic       pedRequest,
  output logic       windowTick
);

  // state     | meaning
  // PED_IDLE  | no pedestrian request outstanding
  // PED_WAIT  | request held until the controller reports the crossing served
  typedef enum logic {
    PED_IDLE = 1'b0,
    PED_WAIT = 1'b1
  } ped_state_t;

  localparam int WIN_W = 16;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic inc);
    return (inc && (value != 3'd7)) ? value + 3'd1 : value;
  endfunction

  logic main_s1, main_s2, main_prev;
  logic side_s1, side_s2, side_prev;
  logic ped_s1, ped_s2;
  logic main_event, side_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_s1   <= 1'b0;
      main_s2   <= 1'b0;
      main_prev <= 1'b0;
      side_s1   <= 1'b0;
      side_s2   <= 1'b0;
      side_prev <= 1'b0;
      ped_s1    <= 1'b0;
      ped_s2    <= 1'b0;
    end else begin
      main_s1   <= mainSensorRaw;
      main_s2   <= main_s1;
      main_prev <= main_s2;
      side_s1   <= sideSensorRaw;
      side_s2   <= side_s1;
      side_prev <= side_s2;
      ped_s1    <= pedButtonRaw;
      ped_s2    <= ped_s1;
    end
  end

  assign main_event = main_s2 & ~main_prev;
  assign side_event = side_s2 & ~side_prev;

  logic [WIN_W-1:0] win_cnt;
  logic             terminal;

  assign terminal = (win_cnt == WIN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (terminal) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 16'd1;
    end
  end

  logic [2:0] main_acc, side_acc;

  // An event landing on the terminal cycle is folded into the closing window's published count.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_acc    <= 3'd0;
      side_acc    <= 3'd0;
      mainTraffic <= 3'd0;
      sideTraffic <= 3'd0;
      windowTick  <= 1'b0;
    end else begin
      windowTick <= terminal;
      if (terminal) begin
        mainTraffic <= sat_inc(main_acc, main_event);
        sideTraffic <= sat_inc(side_acc, side_event);
        main_acc    <= 3'd0;
        side_acc    <= 3'd0;
      end else begin
        main_acc <= sat_inc(main_acc, main_event);
        side_acc <= sat_inc(side_acc, side_event);
      end
    end
  end

  logic ped_level;

`ifdef PED_DEBOUNCE_EN
  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [7:0] stable_cnt;
  logic       deb_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt <= 8'd0;
      deb_level  <= 1'b0;
    end else if (ped_s2 == deb_level) begin
      stable_cnt <= 8'd0;
    end else if ((stable_cnt + 8'd1) == DEB_LIMIT) begin
      deb_level  <= ped_s2;
      stable_cnt <= 8'd0;
    end else begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  assign ped_level = deb_level;
`else
  logic unused_debounce_cfg;

  assign ped_level           = ped_s2;
  assign unused_debounce_cfg = ^8'(DEBOUNCE_CYCLES);
`endif

  logic ped_prev;
  logic ped_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_prev <= 1'b0;
    end else begin
      ped_prev <= ped_level;
    end
  end

  assign ped_rise = ped_level & ~ped_prev;

  ped_state_t ped_state, ped_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_state <= PED_IDLE;
    end else begin
      ped_state <= ped_next;
    end
  end

  // A press coinciding with pedServed is already satisfied by the walk phase just ending.
  always_comb begin
    ped_next = ped_state;
    case (ped_state)
      PED_IDLE: if (ped_rise && !pedServed) ped_next = PED_WAIT;
      PED_WAIT: if (pedServed) ped_next = PED_IDLE;
      default:  ped_next = PED_IDLE;
    endcase
  end

  assign pedRequest = (ped_state == PED_WAIT);

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: per-cycle comparison against a window/queue model plus literal pins.
module tb_traffic_sensor_conditioner;

  localparam int W  = 16;
  localparam int D  = 8;
`ifdef PED_DEBOUNCE_EN
  localparam int PED_LAT = D + 3;
`else
  localparam int PED_LAT = 3;
`endif
  localparam int P1 = 100;
  localparam int P2 = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mainSensorRaw = 1'b0;
  logic       sideSensorRaw = 1'b0;
  logic       pedButtonRaw = 1'b0;
  logic       pedServed = 1'b0;
  logic [2:0] mainTraffic;
  logic [2:0] sideTraffic;
  logic       pedRequest;
  logic       windowTick;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .WINDOW_CYCLES(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mainSensorRaw(mainSensorRaw),
    .sideSensorRaw(sideSensorRaw),
    .pedButtonRaw(pedButtonRaw),
    .pedServed(pedServed),
    .mainTraffic(mainTraffic),
    .sideTraffic(sideTraffic),
    .pedRequest(pedRequest),
    .windowTick(windowTick)
  );

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int min7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Model: raw sample histories (bit0 = previous edge, bit1 = two edges ago, bit2 = three edges ago).
  logic [2:0] hm, hs, hp;
  int ecnt, acc_m, acc_s, exp_main, exp_side, run;
  bit exp_tick, exp_req, dlev, dlev_prev;

  always @(posedge clk) begin
    bit ev_m, ev_s, rise;
    if (reset) begin
      hm = '0; hs = '0; hp = '0;
      ecnt = 0; acc_m = 0; acc_s = 0; run = 0;
      exp_main = 0; exp_side = 0; exp_tick = 0; exp_req = 0;
      dlev = 0; dlev_prev = 0;
    end else begin
      ev_m = hm[1] & ~hm[2];
      ev_s = hs[1] & ~hs[2];
      if (ecnt % W == W - 1) begin
        exp_main = min7(acc_m + int'(ev_m));
        exp_side = min7(acc_s + int'(ev_s));
        acc_m = 0;
        acc_s = 0;
        exp_tick = 1;
      end else begin
        acc_m += int'(ev_m);
        acc_s += int'(ev_s);
        exp_tick = 0;
      end
`ifdef PED_DEBOUNCE_EN
      rise = dlev & ~dlev_prev;
      dlev_prev = dlev;
      if (hp[1] == dlev) run = 0;
      else begin
        run++;
        if (run == D) begin
          dlev = hp[1];
          run = 0;
        end
      end
`else
      rise = hp[1] & ~hp[2];
`endif
      if (pedServed) exp_req = 0;
      else if (rise) exp_req = 1;
      ecnt++;
      hm = {hm[1:0], mainSensorRaw};
      hs = {hs[1:0], sideSensorRaw};
      hp = {hp[1:0], pedButtonRaw};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mainTraffic", mainTraffic, exp_main);
      check("sideTraffic", sideTraffic, exp_side);
      check("windowTick", windowTick, exp_tick);
      check("pedRequest", pedRequest, exp_req);
    end
  end

  function automatic logic main_pat(input int s);
    return ((s < 15) && (s % 3 != 2)) || (s == 45) || (s == 46);
  endfunction

  function automatic logic side_pat(input int s);
    return (s >= 1 && s <= 2) || (s >= 6 && s <= 7) || (s >= 30 && s <= 44 && s % 2 == 0);
  endfunction

  function automatic logic ped_pat(input int s);
    return (s >= 64 && s < 94 && ((s - 64) / 3) % 2 == 0) ||
           (s >= P1 && s <= 140 && s != 112 && s != 113) ||
           (s >= P2 && s <= 185);
  endfunction

  function automatic logic main_pat3(input int s);
    return (s % 3 != 2) && (s <= 10 || (s >= 16 && s <= 26));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    step();
    check("reset mainTraffic", mainTraffic, 0);
    check("reset sideTraffic", sideTraffic, 0);
    check("reset windowTick", windowTick, 0);
    check("reset pedRequest", pedRequest, 0);

    reset = 1'b0;
    for (int s = 0; s < 64; s++) begin
      mainSensorRaw = main_pat(s);
      sideSensorRaw = side_pat(s);
      step();
      case (s)
        0:  check("first cycle tick", windowTick, 0);
        14: check("no early tick", windowTick, 0);
        15: begin
          check("tick 15", windowTick, 1);
          check("count main 5", mainTraffic, 5);
          check("count side 2", sideTraffic, 2);
        end
        16: check("tick one cycle", windowTick, 0);
        31: begin
          check("tick 31", windowTick, 1);
          check("idle window main", mainTraffic, 0);
          check("idle window side", sideTraffic, 0);
        end
        47: begin
          check("side saturates", sideTraffic, 7);
          check("terminal event main", mainTraffic, 1);
        end
        63: check("next window from 0", mainTraffic, 0);
        default: ;
      endcase
    end

    mainSensorRaw = 1'b0;
    sideSensorRaw = 1'b0;
    for (int s = 64; s < 190; s++) begin
      pedButtonRaw = ped_pat(s);
      pedServed = (s == 96) || (s == 120) || (s == P2 + PED_LAT - 1);
      step();
`ifdef PED_DEBOUNCE_EN
      if (s == 95) check("bounce ignored", pedRequest, 0);
`endif
      if (s == P1 + PED_LAT - 2) check("press before latency", pedRequest, 0);
      if (s == P1 + PED_LAT - 1) check("press at latency", pedRequest, 1);
      if (s == 119) check("held through re-press", pedRequest, 1);
      if (s == 120) check("served clears", pedRequest, 0);
      if (s == 125) check("held button no re-request", pedRequest, 0);
      if (s == P2 + PED_LAT - 1) check("served wins over set", pedRequest, 0);
      if (s == P2 + PED_LAT + 4) check("served wins stays", pedRequest, 0);
    end

    pedButtonRaw = 1'b0;
    pedServed = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int s = 0; s < 29; s++) begin
      if (s == 28) reset = 1'b1;
      mainSensorRaw = main_pat3(s);
      step();
      if (s == 15) check("pre-reset main 4", mainTraffic, 4);
      if (s == 28) begin
        check("mid-window reset main", mainTraffic, 0);
        check("mid-window reset tick", windowTick, 0);
      end
    end
    step();
    reset = 1'b0;
    mainSensorRaw = 1'b0;
    for (int s = 0; s < 17; s++) begin
      step();
      if (s == 14) check("restart no early tick", windowTick, 0);
      if (s == 15) begin
        check("restart tick 15", windowTick, 1);
        check("restart discarded count", mainTraffic, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
